// File: rtl/m16_monitor.sv
// m16_monitor: receive-side checker for a mod-16 up-counter (value, fifteen, altFifteen).
// Define M16_MON_WRAP_CNT_EN to add the wrap_count port and register.
module m16_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             clear,
    input  logic [3:0]       value,
    input  logic             fifteen,
    input  logic             altFifteen,
    output logic             locked,
    output logic             seq_err,
    output logic             flag_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
`ifdef M16_MON_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_count
`endif
);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || ERR_W < 1 || WRAP_W < 1) begin : g_param_check
        $error("m16_monitor: parameter out of range");
    end

    typedef enum logic [1:0] {UNLOCKED, TRACKING, LOCKED} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

    state_t           state, state_nx;
    logic [3:0]       prev, prev_nx;
    logic [3:0]       run, run_nx;
    logic             seq_nx, flag_nx, wrap_nx;
    logic [ERR_W-1:0] err_nx;
    logic             correct, flag_bad, is_f;

    assign is_f     = (value == 4'hF);
    assign correct  = (value == prev + 4'd1);
    assign flag_bad = (fifteen != is_f) || (altFifteen != is_f);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        run_nx   = run;
        seq_nx   = 1'b0;
        flag_nx  = 1'b0;
        wrap_nx  = 1'b0;
        err_nx   = err_count;
        if (clear) begin
            state_nx = UNLOCKED;
            run_nx   = 4'd0;
            err_nx   = '0;
        end else if (sample_en) begin
            prev_nx = value;
            flag_nx = flag_bad;
            wrap_nx = (state == LOCKED) && (prev == 4'hF) && (value == 4'h0);
            case (state)
                UNLOCKED: begin
                    run_nx   = 4'd0;
                    state_nx = TRACKING;
                end
                TRACKING: begin
                    if (correct) begin
                        run_nx = run + 4'd1;
                        if (run + 4'd1 == LOCK_RUN) state_nx = LOCKED;
                    end else begin
                        run_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!correct) begin
                        seq_nx   = 1'b1;
                        run_nx   = 4'd0;
                        state_nx = TRACKING;
                    end
                end
                default: state_nx = UNLOCKED;
            endcase
            // A simultaneous sequence and flag error is one bad sample: count once.
            if ((seq_nx || flag_nx) && (err_count != '1)) err_nx = err_count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= UNLOCKED;
            prev      <= 4'd0;
            run       <= 4'd0;
            seq_err   <= 1'b0;
            flag_err  <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            prev      <= prev_nx;
            run       <= run_nx;
            seq_err   <= seq_nx;
            flag_err  <= flag_nx;
            wrap      <= wrap_nx;
            err_count <= err_nx;
        end
    end

`ifdef M16_MON_WRAP_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        wrap_count <= '0;
        else if (clear)   wrap_count <= '0;
        else if (wrap_nx) wrap_count <= wrap_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_m16_monitor.sv
// Bench for m16_monitor: directed sequences plus random traffic against a streak-based model.
// Two instances share stimulus: default widths and ERR_W=2 for saturation.
module tb_m16_monitor;
    localparam int LOCK_COUNT = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       sample_en, clear, fifteen, altFifteen;
    logic [3:0] value;
    logic       locked, seq_err, flag_err, wrap;
    logic [7:0] err_count;
    logic       locked2, seq_err2, flag_err2, wrap2;
    logic [1:0] err_count2;
`ifdef M16_MON_WRAP_CNT_EN
    logic [15:0] wrap_count, wrap_count2;
`endif

    m16_monitor #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(8), .WRAP_W(16)) dut (
        .clock(clock), .reset(reset), .sample_en(sample_en), .clear(clear),
        .value(value), .fifteen(fifteen), .altFifteen(altFifteen),
        .locked(locked), .seq_err(seq_err), .flag_err(flag_err), .wrap(wrap),
        .err_count(err_count)
`ifdef M16_MON_WRAP_CNT_EN
        , .wrap_count(wrap_count)
`endif
    );

    m16_monitor #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(2), .WRAP_W(16)) dut2 (
        .clock(clock), .reset(reset), .sample_en(sample_en), .clear(clear),
        .value(value), .fifteen(fifteen), .altFifteen(altFifteen),
        .locked(locked2), .seq_err(seq_err2), .flag_err(flag_err2), .wrap(wrap2),
        .err_count(err_count2)
`ifdef M16_MON_WRAP_CNT_EN
        , .wrap_count(wrap_count2)
`endif
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a stream of samples, the length of the current run of +1 steps,
    // and running totals of bad samples and observed wraps.
    bit         have_prev;
    int         streak;
    logic [3:0] m_prev;
    int         m_err, m_wraps;
    bit         m_seq, m_flg, m_wrp;

    function automatic bit m_locked();
        return have_prev && (streak >= LOCK_COUNT);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("locked",    32'(locked),    32'(m_locked()));
        check("seq_err",   32'(seq_err),   32'(m_seq));
        check("flag_err",  32'(flag_err),  32'(m_flg));
        check("wrap",      32'(wrap),      32'(m_wrp));
        check("err_count", 32'(err_count), 32'((m_err > 255) ? 255 : m_err));
        check("err_count_w2", 32'(err_count2), 32'((m_err > 3) ? 3 : m_err));
        check("locked_w2", 32'(locked2),   32'(m_locked()));
`ifdef M16_MON_WRAP_CNT_EN
        check("wrap_count", 32'(wrap_count), 32'(m_wraps % 65536));
`endif
    endtask

    task automatic model_reset();
        have_prev = 0; streak = 0; m_prev = 4'd0;
        m_err = 0; m_wraps = 0;
        m_seq = 0; m_flg = 0; m_wrp = 0;
    endtask

    task automatic step(bit en, bit clr, logic [3:0] v, bit f, bit af);
        bit was_locked;
        sample_en = en; clear = clr; value = v; fifteen = f; altFifteen = af;
        @(posedge clock); #1;
        m_seq = 0; m_flg = 0; m_wrp = 0;
        if (clr) begin
            have_prev = 0; streak = 0; m_err = 0; m_wraps = 0;
        end else if (en) begin
            was_locked = m_locked();
            if (!have_prev) begin
                have_prev = 1; streak = 0;
            end else if (int'(v) == (int'(m_prev) + 1) % 16) begin
                streak++;
            end else begin
                m_seq = was_locked; streak = 0;
            end
            m_flg = (f != (v == 4'hF)) || (af != (v == 4'hF));
            m_wrp = was_locked && (m_prev == 4'hF) && (v == 4'h0);
            if (m_seq || m_flg) m_err++;
            if (m_wrp) m_wraps++;
            m_prev = v;
        end
        check_all();
    endtask

    task automatic go(logic [3:0] v);
        step(1'b1, 1'b0, v, v == 4'hF, v == 4'hF);
    endtask

    task automatic async_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [3:0] rv;
        bit         ren, rclr, rf, raf;
        int         r;

        reset = 1'b1; sample_en = 0; clear = 0; value = 0; fifteen = 0; altFifteen = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Count 0..15,0,1: lock on the 5th edge, one wrap, no errors.
        for (int i = 0; i < 18; i++) begin
            go(4'(i));
            if (i == 3) check("not_locked_4th", 32'(locked), 32'(0));
            if (i == 4) check("locked_5th", 32'(locked), 32'(1));
        end
        check("err_after_count", 32'(err_count), 32'(0));

        // Skip 6: one seq_err, then relock after 8,9,10,11.
        for (int i = 2; i <= 5; i++) go(4'(i));
        go(4'd7);
        check("skip_seq_err", 32'(seq_err), 32'(1));
        for (int i = 8; i <= 11; i++) go(4'(i));
        check("relocked", 32'(locked), 32'(1));

        // Flag mismatches, then a combined sequence + flag error.
        go(4'd12); go(4'd13); go(4'd14);
        step(1'b1, 1'b0, 4'hF, 1'b0, 1'b1);
        check("f_mismatch", 32'(flag_err), 32'(1));
        go(4'd0); go(4'd1); go(4'd2);
        step(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        check("alt_mismatch", 32'(flag_err), 32'(1));
        step(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
        check("combo_err", 32'(err_count), 32'(4));

        // Relock, run to 9, then hold for 3 edges with random inputs.
        for (int i = 10; i < 26; i++) go(4'(i % 16));
        check("locked_at_9", 32'(locked), 32'(1));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        go(4'd10);
        check("resume_no_err", 32'(seq_err), 32'(0));

        // Five sequence errors with a relock between each.
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) go(4'(i));
        for (int k = 0; k < 5; k++) begin
            go(m_prev + 4'd2);
            for (int i = 0; i < 4; i++) go(m_prev + 4'd1);
        end
        check("sat_w2", 32'(err_count2), 32'(3));
        check("sat_w8", 32'(err_count), 32'(5));

        // Async reset while locked, then clear with a bad sample.
        async_reset();
        for (int i = 0; i < 6; i++) go(4'(i));
        step(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
        check("clear_locked", 32'(locked), 32'(0));

        // Two wraps from a fresh start.
        for (int i = 0; i < 33; i++) go(4'(i % 16));
`ifdef M16_MON_WRAP_CNT_EN
        check("wrap_count_two", 32'(wrap_count), 32'(2));
`endif

        // Random traffic: mostly correct increments, occasional breaks, holds, clears, resets.
        for (int n = 0; n < 400; n++) begin
            r    = int'($urandom_range(0, 99));
            ren  = (r < 90);
            rclr = (r >= 97);
            rv   = ($urandom_range(0, 9) < 8) ? m_prev + 4'd1 : 4'($urandom_range(0, 15));
            rf   = (rv == 4'hF) ^ ($urandom_range(0, 19) == 0);
            raf  = (rv == 4'hF) ^ ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            step(ren, rclr, rv, rf, raf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
